// File: rtl/phaser_ctrl_pkg.sv
// Shared state encoding, counter widths and helpers for the PHASER_REF
// lock controllers.
package phaser_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN  = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_READY  = 3'd4,
    ST_FAIL   = 3'd5,
    ST_SLEEP  = 3'd6
  } phref_state_e;

  localparam int LOSS_CNT_W = 8;
  localparam int RETRY_W    = 3;

  typedef struct packed {
    logic pwrdwn;
    logic rst;
    logic ready;
    logic fail;
  } phref_outs_t;

  // Pin/status levels presented while resident in a given state.
  function automatic phref_outs_t state_outs(input phref_state_e st);
    phref_outs_t o;
    case (st)
      ST_PWRDN:  o = '{pwrdwn: 1'b1, rst: 1'b1, ready: 1'b0, fail: 1'b0};
      ST_RESET:  o = '{pwrdwn: 1'b0, rst: 1'b1, ready: 1'b0, fail: 1'b0};
      ST_READY:  o = '{pwrdwn: 1'b0, rst: 1'b0, ready: 1'b1, fail: 1'b0};
      ST_FAIL:   o = '{pwrdwn: 1'b1, rst: 1'b1, ready: 1'b0, fail: 1'b1};
      ST_SLEEP:  o = '{pwrdwn: 1'b1, rst: 1'b1, ready: 1'b0, fail: 1'b0};
      default:   o = '{pwrdwn: 1'b0, rst: 1'b0, ready: 1'b0, fail: 1'b0};
    endcase
    return o;
  endfunction

  // Narrowest cycle timer that can reach every terminal count.
  function automatic int min_cnt_w(input int pwrdn_cycles, input int rst_cycles,
                                   input int lock_timeout, input int stable_cycles);
    int m;
    m = pwrdn_cycles;
    if (rst_cycles > m)    m = rst_cycles;
    if (lock_timeout > m)  m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer; data path carries no reset so the
// flops can be placed as a plain synchronizer pair.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end

  assign q = sync_q;

endmodule

// File: rtl/phaser_ref_lock_ctrl.sv
// PHASER_REF sequencer: power-down / reset pacing, lock qualification with
// timeout retries, lock-loss recovery, sleep handling and READY/FAIL status.
module phaser_ref_lock_ctrl
  import phaser_ctrl_pkg::*;
#(
  parameter int PWRDN_CYCLES  = 16,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED_IN,
  input  logic       RESTART,
  input  logic       SLEEP_REQ,
  output logic       PHREF_PWRDWN,
  output logic       PHREF_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [2:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] STATE
);

  // An undersized CNT_W is widened rather than allowed to wrap short.
  localparam int CNT_MIN     = min_cnt_w(PWRDN_CYCLES, RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TMR_W       = (CNT_W > CNT_MIN) ? CNT_W : CNT_MIN;
  localparam int RETRY_LIMIT = (MAX_RETRY > 7) ? 7 : MAX_RETRY;

  localparam logic [TMR_W-1:0]   PWRDN_LAST  = TMR_W'(PWRDN_CYCLES - 1);
  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
  // The WAIT cycle that first sees lock_s counts toward the stable run.
  localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(RETRY_LIMIT);

  phref_state_e            state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [TMR_W-1:0]        tmo_q, tmo_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  phref_outs_t             outs_q, outs_d;
  logic                    lock_s;
  logic                    in_lock_win;
  logic                    tmo_hit;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .d   (LOCKED_IN),
    .q   (lock_s)
  );

  assign in_lock_win = (state_q == ST_WAIT) || (state_q == ST_STABLE);
  assign tmo_hit     = in_lock_win && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (RESTART) begin
      state_d = ST_PWRDN;
      retry_d = '0;
    end else if (SLEEP_REQ && (state_q != ST_FAIL)) begin
      state_d = ST_SLEEP;
    end else begin
      case (state_q)
        ST_PWRDN:  if (timer_q == PWRDN_LAST) state_d = ST_RESET;
        ST_RESET:  if (timer_q == RST_LAST) state_d = ST_WAIT;
        ST_WAIT, ST_STABLE: begin
          if (tmo_hit) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_PWRDN;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (state_q == ST_WAIT) begin
            if (lock_s) state_d = (STABLE_CYCLES > 1) ? ST_STABLE : ST_READY;
          end else if (!lock_s) begin
            state_d = ST_WAIT;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (!lock_s) begin
            if (loss_q != '1) loss_d = loss_q + 1'b1;
            state_d = ST_PWRDN;
          end
        end
        ST_FAIL:   state_d = ST_FAIL;
        ST_SLEEP:  state_d = ST_PWRDN;
        default:   state_d = ST_PWRDN;
      endcase
    end
    if ((state_d == ST_READY) && (state_q != ST_READY)) retry_d = '0;
  end

  // Timer restarts on any entry (including RESTART back into PWRDN); tmo spans WAIT+STABLE.
  always_comb begin
    if (RESTART || (state_d != state_q)) timer_d = '0;
    else if (timer_q != '1)              timer_d = timer_q + 1'b1;
    else                                 timer_d = timer_q;

    if (in_lock_win && ((state_d == ST_WAIT) || (state_d == ST_STABLE))) tmo_d = tmo_q + 1'b1;
    else                                                                  tmo_d = '0;

    outs_d = state_outs(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_PWRDN;
      timer_q <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      outs_q  <= state_outs(ST_PWRDN);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      outs_q  <= outs_d;
    end
  end

  assign PHREF_PWRDWN = outs_q.pwrdwn;
  assign PHREF_RST    = outs_q.rst;
  assign READY        = outs_q.ready;
  assign FAIL         = outs_q.fail;
  assign RETRY_CNT    = retry_q;
  assign LOSS_CNT     = loss_q;
  assign STATE        = state_q;

endmodule
